// File: rtl/ksa_schedule.sv
// RC4 key-scheduling stage: fills the shared S RAM with the identity permutation,
// then runs the 256-round KSA swap loop, and pulses finish when S is ready.
module ksa_schedule #(
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_sig,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  input  logic [7:0]              q_data,
  output logic                    finish,
  output logic                    ksa_mem_handler,
  output logic [7:0]              address,
  output logic [7:0]              data,
  output logic                    wen
);

  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(KEY_LENGTH - 1);

  typedef enum logic [3:0] {
    IDLE, START, INIT_WRITE,
    SETUP_READ_I, READ_I, SAMPLE_I, ADD_J,
    SETUP_READ_J, READ_J, SAMPLE_J,
    WRITE_I, WRITE_J, INC_I, FINISHED
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      i_q, i_d, j_q, j_d, ti_q, ti_d, tj_q, tj_d;
  logic [KW-1:0]   kidx_q, kidx_d;
  logic            fin_q, fin_d, own_q, own_d, wen_q, wen_d;
  logic [7:0]      addr_q, addr_d, data_q, data_d;

  // Key bytes indexed with key[0] = MSB; padded to a power of two so kidx never indexes out of range.
  logic [7:0] key_bytes [2**KW];
  for (genvar k = 0; k < 2**KW; k++) begin : g_key
    if (k < KEY_LENGTH) begin : g_real
      assign key_bytes[k] = secret_key[8*(KEY_LENGTH-1-k) +: 8];
    end else begin : g_pad
      assign key_bytes[k] = 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    ti_d    = ti_q;
    tj_d    = tj_q;
    kidx_d  = kidx_q;
    fin_d   = 1'b0;
    own_d   = 1'b1;
    wen_d   = 1'b0;
    addr_d  = 8'h00;
    data_d  = 8'h00;
    case (state_q)
      IDLE: begin
        own_d = 1'b0;
        if (start_sig) state_d = START;
      end
      START: begin
        i_d     = 8'h00;
        j_d     = 8'h00;
        kidx_d  = '0;
        state_d = INIT_WRITE;
      end
      INIT_WRITE: begin
        wen_d  = 1'b1;
        addr_d = i_q;
        data_d = i_q;
        i_d    = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = SETUP_READ_I;
      end
      // Read address is held across the read states so the RAM sees it a cycle later.
      SETUP_READ_I: begin addr_d = i_q; state_d = READ_I; end
      READ_I:       begin addr_d = i_q; state_d = SAMPLE_I; end
      SAMPLE_I:     begin addr_d = i_q; ti_d = q_data; state_d = ADD_J; end
      ADD_J: begin
        j_d     = j_q + ti_q + key_bytes[kidx_q];
        state_d = SETUP_READ_J;
      end
      SETUP_READ_J: begin addr_d = j_q; state_d = READ_J; end
      READ_J:       begin addr_d = j_q; state_d = SAMPLE_J; end
      SAMPLE_J:     begin addr_d = j_q; tj_d = q_data; state_d = WRITE_I; end
      WRITE_I: begin
        wen_d = 1'b1; addr_d = i_q; data_d = tj_q; state_d = WRITE_J;
      end
      WRITE_J: begin
        wen_d = 1'b1; addr_d = j_q; data_d = ti_q; state_d = INC_I;
      end
      INC_I: begin
        if (i_q == 8'hFF) begin
          state_d = FINISHED;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KLAST) ? '0 : kidx_q + KW'(1);
          state_d = SETUP_READ_I;
        end
      end
      FINISHED: begin
        fin_d   = 1'b1;
        own_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        own_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      ti_q    <= 8'h00;
      tj_q    <= 8'h00;
      kidx_q  <= '0;
      fin_q   <= 1'b0;
      own_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ti_q    <= ti_d;
      tj_q    <= tj_d;
      kidx_q  <= kidx_d;
      fin_q   <= fin_d;
      own_q   <= own_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign finish          = fin_q;
  assign ksa_mem_handler = own_q;
  assign wen             = wen_q;
  assign address         = addr_q;
  assign data            = data_q;

endmodule

// File: tb/tb_ksa_schedule.sv
// Bench for ksa_schedule: behavioural S RAM plus a software RC4 KSA reference.
module tb_ksa_schedule;
  localparam int KL = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start_sig = 1'b0;
  logic [8*KL-1:0] secret_key = '0;
  logic [7:0]      q_data;
  logic            finish, ksa_mem_handler, wen;
  logic [7:0]      address, data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  logic [7:0] mem [256];
  wr_t        wlog[$];
  int         wcyc[$];
  logic [7:0] exp_s [256];
  wr_t        exp_w[$];

  ksa_schedule #(.KEY_LENGTH(KL)) dut (
    .clk(clk), .reset(reset), .start_sig(start_sig), .secret_key(secret_key),
    .q_data(q_data), .finish(finish), .ksa_mem_handler(ksa_mem_handler),
    .address(address), .data(data), .wen(wen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (wen === 1'b1) mem[address] <= data;
    q_data <= mem[address];
  end

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wlog.push_back(wr_t'({address, data}));
      wcyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end");
    $fatal(1);
  end

  // Software RC4 KSA producing final S and the expected RAM write stream.
  function automatic void ksa_model(input logic [8*KL-1:0] key);
    int jj;
    logic [7:0] kb [KL];
    logic [7:0] t;
    for (int k = 0; k < KL; k++) kb[k] = key[8*(KL-1-k) +: 8];
    exp_w.delete();
    for (int n = 0; n < 256; n++) begin
      exp_s[n] = 8'(n);
      exp_w.push_back(wr_t'({8'(n), 8'(n)}));
    end
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      jj = (jj + int'(exp_s[ii]) + int'(kb[ii % KL])) % 256;
      exp_w.push_back(wr_t'({8'(ii), exp_s[jj]}));
      exp_w.push_back(wr_t'({8'(jj), exp_s[ii]}));
      t = exp_s[ii]; exp_s[ii] = exp_s[jj]; exp_s[jj] = t;
    end
  endfunction

  // Launches one schedule and observes 3000 cycles; collects latency, finish count, handler behaviour.
  task automatic do_run(input logic [8*KL-1:0] key, input bit pulse_mid,
                        output int lat, output int nfin, output bit h_ok);
    int s;
    bit hprev;
    wlog.delete(); wcyc.delete();
    @(negedge clk); secret_key = key; start_sig = 1'b1;
    @(negedge clk); start_sig = 1'b0; s = cyc;
    lat = -1; nfin = 0; h_ok = 1'b1; hprev = 1'b0;
    for (int t = 1; t <= 3000; t++) begin
      start_sig = pulse_mid && (t == 500 || t == 1500 || t == 2700);
      @(negedge clk);
      if (finish === 1'b1) begin
        nfin++;
        if (lat < 0) lat = cyc - s;
        if (ksa_mem_handler !== 1'b0 || hprev !== 1'b1) h_ok = 1'b0;
      end else if (lat < 0 && t > 1 && ksa_mem_handler !== 1'b1) begin
        h_ok = 1'b0;
      end
      hprev = ksa_mem_handler;
    end
    start_sig = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1; start_sig = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({finish, ksa_mem_handler, wen, address, data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {finish, ksa_mem_handler, wen, address, data});
    end
    reset = 1'b0;
    wlog.delete();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({finish, ksa_mem_handler, wen, address, data} !== 19'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_outputs: got %0d nonzero cycles want 0", bad);
    end
    checks++;
    if (wlog.size() !== 0) begin
      errors++;
      $display("FAIL idle_writes: got %0d writes want 0", wlog.size());
    end
  endtask

  task automatic test_init_key0;
    int lat, nfin, bad;
    bit h_ok;
    wr_t hand [6];
    hand[0] = wr_t'(16'h0000); hand[1] = wr_t'(16'h0000);
    hand[2] = wr_t'(16'h0101); hand[3] = wr_t'(16'h0101);
    hand[4] = wr_t'(16'h0203); hand[5] = wr_t'(16'h0302);
    do_run(24'h000000, 1'b0, lat, nfin, h_ok);
    checks++;
    if (wlog.size() !== 768) begin
      errors++;
      $display("FAIL key0_write_count: got %0d want 768", wlog.size());
    end else begin
      bad = 0;
      for (int n = 0; n < 256; n++) if (wlog[n] !== wr_t'({8'(n), 8'(n)})) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL init_writes: got %0d wrong entries want 0", bad);
      end
      checks++;
      if (wcyc[255] - wcyc[0] !== 255) begin
        errors++;
        $display("FAIL init_contiguous: got span %0d want 255", wcyc[255] - wcyc[0]);
      end
      for (int n = 0; n < 6; n++) begin
        checks++;
        if (wlog[256+n] !== hand[n]) begin
          errors++;
          $display("FAIL key0_swap%0d: got %h want %h", n, wlog[256+n], hand[n]);
        end
      end
    end
    checks++;
    if (lat !== 2818 || nfin !== 1) begin
      errors++;
      $display("FAIL key0_finish: got lat %0d pulses %0d want 2818 1", lat, nfin);
    end
  endtask

  task automatic test_key_wrap;
    int lat, nfin, bad;
    bit h_ok;
    wr_t hand [8];
    hand[0] = wr_t'(16'h0001); hand[1] = wr_t'(16'h0100);
    hand[2] = wr_t'(16'h0103); hand[3] = wr_t'(16'h0300);
    hand[4] = wr_t'(16'h0208); hand[5] = wr_t'(16'h0802);
    hand[6] = wr_t'(16'h0309); hand[7] = wr_t'(16'h0900);
    do_run(24'h010203, 1'b0, lat, nfin, h_ok);
    ksa_model(24'h010203);
    checks++;
    if (wlog.size() !== 768) begin
      errors++;
      $display("FAIL wrap_write_count: got %0d want 768", wlog.size());
    end else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (wlog[256+n] !== hand[n]) begin
          errors++;
          $display("FAIL wrap_round%0d: got %h want %h", n/2, wlog[256+n], hand[n]);
        end
      end
      bad = 0;
      for (int n = 0; n < 768; n++) if (wlog[n] !== exp_w[n]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL wrap_write_stream: got %0d wrong entries want 0", bad);
      end
    end
  endtask

  task automatic test_random;
    int lat, nfin, bad;
    bit h_ok;
    logic [8*KL-1:0] key;
    for (int r = 0; r < 10; r++) begin
      key = 24'($urandom);
      do_run(key, 1'b0, lat, nfin, h_ok);
      ksa_model(key);
      bad = 0;
      for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rand%0d_ram key %h: got %0d wrong bytes want 0", r, key, bad);
      end
      checks++;
      if (lat !== 2818 || nfin !== 1) begin
        errors++;
        $display("FAIL rand%0d_finish: got lat %0d pulses %0d want 2818 1", r, lat, nfin);
      end
      checks++;
      if (h_ok !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_handler: got bad ownership timing want clean fall at finish", r);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int lat, nfin, bad;
    bit h_ok;
    logic [8*KL-1:0] key;
    key = 24'($urandom);
    @(negedge clk); secret_key = key; start_sig = 1'b1;
    @(negedge clk); start_sig = 1'b0;
    repeat (1260) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({finish, ksa_mem_handler, wen, address, data} !== 19'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %b want 0", {finish, ksa_mem_handler, wen, address, data});
    end
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (finish !== 1'b0 || ksa_mem_handler !== 1'b0 || wen !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrun_stays_idle: got %0d active cycles want 0", bad);
    end
    key = 24'($urandom);
    do_run(key, 1'b1, lat, nfin, h_ok);
    ksa_model(key);
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL restart_ram: got %0d wrong bytes want 0", bad);
    end
    checks++;
    if (lat !== 2818 || nfin !== 1 || wlog.size() !== 768) begin
      errors++;
      $display("FAIL restart_timing: got lat %0d pulses %0d writes %0d want 2818 1 768",
               lat, nfin, wlog.size());
    end
    checks++;
    if (h_ok !== 1'b1 || ksa_mem_handler !== 1'b0) begin
      errors++;
      $display("FAIL restart_handler: got h_ok %0b handler %0b want 1 0", h_ok, ksa_mem_handler);
    end
  endtask

  initial begin
    test_reset();
    test_init_key0();
    test_key_wrap();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ksa_schedule.md
# ksa_schedule

RC4 key-scheduling stage, directly upstream of the PRGA decrypt FSM. It owns the S working memory, a 256×8 synchronous single-port RAM, while it runs. On a start pulse it initialises S[i] = i, then performs the 256-round KSA swap loop driven by `secret_key`. It then pulses `finish`, after which the top-level controller starts the decrypt stage on the same S memory.

## Interface
Parameters:
- `KEY_LENGTH`, default 3: key length in bytes; `secret_key` width is 8×KEY_LENGTH.

Ports:
- `clk`  input  1: single clock; all logic on the rising edge.
- `reset`  input  1: synchronous, active-high; returns the FSM to IDLE and clears all outputs.
- `start_sig`  input  1: sampled only in IDLE; a high level launches one schedule.
- `secret_key`  input  8×KEY_LENGTH: key[0] = most-significant byte; must stay stable from start until `finish`.
- `q_data`  input  8: S RAM read data.
- `finish`  output  1: one-cycle pulse when S is fully scheduled.
- `ksa_mem_handler`  output  1: high while this block owns the S RAM port (arbiter select).
- `address`  output  8: S RAM address.
- `data`  output  8: S RAM write data.
- `wen`  output  1: S RAM write enable.

## Operation
- Internal registers:
  - `i`, `j`, `temp_i`, `temp_j`: 8 bits each.
  - `kidx`: key-byte index, range 0..KEY_LENGTH-1.
- All arithmetic is modulo 256 with natural 8-bit wrap.
- Key byte selection: `kidx` tracks i mod KEY_LENGTH without a divider.
  - It increments together with `i` and wraps to 0 after KEY_LENGTH-1.
- FSM states and transitions:
  - IDLE: go to START if `start_sig`, else stay.
  - START: i=0, j=0, kidx=0; go to INIT_WRITE.
  - INIT_WRITE: write S[i]=i (wen=1, address=i, data=i); i++.
    - If i==255, go to SETUP_READ_I; i wraps to 0.
    - Otherwise stay in INIT_WRITE.
  - SETUP_READ_I → READ_I → SAMPLE_I: address=i; temp_i ← q_data in SAMPLE_I.
  - ADD_J: j ← j + temp_i + key[kidx].
  - SETUP_READ_J → READ_J → SAMPLE_J: address=j; temp_j ← q_data in SAMPLE_J.
  - WRITE_I: wen=1, address=i, data=temp_j.
  - WRITE_J: wen=1, address=j, data=temp_i.
  - INC_I: if i==255 go to FINISHED; otherwise i++, kidx++ (with wrap), go to SETUP_READ_I.
  - FINISHED: finish=1, ksa_mem_handler=0; go to IDLE.
- `ksa_mem_handler` is 1 in every state except IDLE and FINISHED.
- `wen` is 1 only in INIT_WRITE, WRITE_I and WRITE_J.
- `data` and `address` are 0 whenever `wen`=0, except during read states, where `address` holds the read address.
- i==j: both writes target the same address with the same value; S is unchanged. No special case is required.
- `start_sig` outside IDLE is ignored. A new schedule requires `start_sig` sampled high in IDLE.

## Timing
- The state register and all outputs are registered; outputs reflect the state of the previous cycle (one-cycle lag).
- Reset values of all outputs are 0: `finish`, `ksa_mem_handler`, `wen`, `data`, `address`.
- RAM read latency:
  - The address is presented in the cycle after SETUP_READ_x.
  - `q_data` is sampled in SAMPLE_x, two cycles after SETUP_READ_x.
- Cycle budget:
  - INIT phase: 256 cycles.
  - Swap loop: 10 cycles per round × 256 rounds = 2560 cycles.
- Latency: `finish` is high in the cycle following the 2818th rising edge after the edge that samples `start_sig` in IDLE. It stays high for exactly 1 cycle.
- Reset mid-operation, in any state: at the next edge, state is IDLE and all outputs are 0.
  - Partial S contents are left as-is.
  - No `finish` pulse is produced.

## Test plan
- Reset then idle: hold `start_sig`=0 for 20 cycles → all outputs stay 0 and no RAM write occurs.
- Init phase, key 0x000000: 256 consecutive writes, address n with data n for n=0..255 → `wen` high for 256 cycles.
- First swaps, key 0x000000, behavioural RAM model:
  - Round i=0: writes (0,0),(0,0).
  - Round i=1: writes (1,1),(1,1).
  - Round i=2: j=3, writes (2,3),(3,2).
- Key 0x010203, round i=0: j=0+0+0x01=1 → writes address 0 data 1, then address 1 data 0. Round i=1 uses key byte 0x02 and round i=3 uses key byte 0x01 again (kidx wrap).
- Full run, random keys ×10, compared against a software KSA:
  - Final RAM contents match exactly.
  - `finish` pulses once, exactly 2818 edges after start.
  - `ksa_mem_handler` falls together with the `finish` pulse.
- Reset asserted at swap round 100, then restart:
  - Outputs are 0 the next cycle.
  - The restarted run reproduces the golden S contents and `finish` timing.
  - `start_sig` pulses during a run are ignored (no restart, timing unchanged).
